// File: rtl/ro_tempsens_scan.sv
// ro_tempsens_scan: multi-channel ring-oscillator temperature-sensor scan engine.
// Scans the channels selected in ch_mask from lowest to highest index. For each channel it
// enables that oscillator, waits for it to settle, then counts its rising edges over
// 2^AVG_LOG2 gate windows of WIN_CYCLES clk cycles each. The averaged count is presented on a
// valid/ready result port.
//
// Optional feature: define RO_TEMPSENS_SATURATE_EN to make the edge counter saturate at
// 2^CNT_W-1 and flag res_ovf. When it is not defined, the counter wraps and res_ovf stays 0.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   ro_in      raw oscillator outputs (asynchronous to clk)
//   ro_en      oscillator enables, one-hot or zero
//   start      single-cycle scan request, accepted only while idle with a non-zero ch_mask
//   ch_mask    channels to scan, captured on an accepted start
//   busy       scan in progress
//   res_data   averaged edge count
//   res_ch     channel index of res_data
//   res_valid  result available
//   res_ready  consumer accepts the result
//   res_ovf    a window of this channel saturated
module ro_tempsens_scan #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WIN_CYCLES    = 1000,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [N_CH-1:0]                               ro_in,
  output logic [N_CH-1:0]                               ro_en,
  input  logic                                          start,
  input  logic [N_CH-1:0]                               ch_mask,
  output logic                                          busy,
  output logic [CNT_W-1:0]                              res_data,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]    res_ch,
  output logic                                          res_valid,
  input  logic                                          res_ready,
  output logic                                          res_ovf
);

  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned ACC_W   = CNT_W + AVG_LOG2;
  localparam int unsigned IDX_W   = AVG_LOG2 + 1;

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [N_CH-1:0]  CH_ONE      = N_CH'(1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LOAD    = TMR_W'(WIN_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSettle, StGate, StAccum, StOut, StNext} state_e;

  state_e           state_q;
  logic [N_CH-1:0]  sync1_q, sync2_q, sync3_q;
  logic [N_CH-1:0]  mask_q;
  logic [CH_W-1:0]  ch_q;
  logic [TMR_W-1:0] tmr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic [IDX_W-1:0] idx_q;
  logic             ovf_q;

  logic [N_CH-1:0]  rise;
  logic             rise_sel;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             sat_hit;
  logic [CH_W-1:0]  first_ch;
  logic [CH_W-1:0]  next_ch;
  logic             has_next;

  // sync2 is the synchronised level, sync3 its previous value.
  assign rise     = sync2_q & ~sync3_q;
  assign rise_sel = rise[ch_q];
  assign acc_sum  = acc_q + ACC_W'(cnt_q);

  always_comb begin
    cnt_inc = cnt_q + CNT_W'(1);
    sat_hit = 1'b0;
`ifdef RO_TEMPSENS_SATURATE_EN
    if (cnt_q == '1) begin
      cnt_inc = cnt_q;
      sat_hit = rise_sel;
    end
`endif
  end

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_ch = CH_W'(i);
      end
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_ch  = CH_W'(i);
        has_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      mask_q    <= '0;
      ch_q      <= '0;
      tmr_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      ro_en     <= '0;
      busy      <= 1'b0;
      res_data  <= '0;
      res_ch    <= '0;
      res_valid <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      sync1_q <= ro_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;

      unique case (state_q)
        StIdle: begin
          if (start && (|ch_mask)) begin
            mask_q  <= ch_mask;
            ch_q    <= first_ch;
            ro_en   <= CH_ONE << first_ch;
            busy    <= 1'b1;
            tmr_q   <= SETTLE_LOAD;
            acc_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            // Flush synchroniser history on SETTLE entry; it refills during the settle wait.
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            state_q <= StSettle;
          end
        end

        StSettle: begin
          if (tmr_q == '0) begin
            tmr_q   <= WIN_LOAD;
            cnt_q   <= '0;
            state_q <= StGate;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        StGate: begin
          if (rise_sel) begin
            cnt_q <= cnt_inc;
          end
          ovf_q <= ovf_q | sat_hit;
          if (tmr_q == '0) begin
            state_q <= StAccum;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        StAccum: begin
          acc_q <= acc_sum;
          if (idx_q == IDX_LAST) begin
            res_data  <= CNT_W'(acc_sum >> AVG_LOG2);
            res_ch    <= ch_q;
            res_ovf   <= ovf_q;
            res_valid <= 1'b1;
            ro_en     <= '0;
            state_q   <= StOut;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            tmr_q   <= WIN_LOAD;
            cnt_q   <= '0;
            state_q <= StGate;
          end
        end

        StOut: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_q   <= StNext;
          end
        end

        StNext: begin
          if (has_next) begin
            ch_q    <= next_ch;
            ro_en   <= CH_ONE << next_ch;
            tmr_q   <= SETTLE_LOAD;
            acc_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            state_q <= StSettle;
          end else begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_tempsens_scan.sv
module tb_ro_tempsens_scan;

  localparam int unsigned N_CH = 4;
  localparam int unsigned WIN  = 100;
  localparam int unsigned AVG  = 2;
  localparam int unsigned SET  = 8;

`ifdef RO_TEMPSENS_SATURATE_EN
  localparam int P4_D2 = 15;
  localparam int P4_O2 = 1;
`else
  localparam int P4_D2 = 9;
  localparam int P4_O2 = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  ro_in = '0;
  logic        start = 1'b0;
  logic [3:0]  ch_mask = '0;
  logic        res_ready = 1'b1;
  logic        quiet = 1'b0;

  logic [3:0]  ro_en, ro_en2;
  logic        busy, busy2;
  logic [15:0] res_data;
  logic [3:0]  res_data2;
  logic [1:0]  res_ch, res_ch2;
  logic        res_valid, res_valid2;
  logic        res_ovf, res_ovf2;

  ro_tempsens_scan #(
    .N_CH(N_CH), .CNT_W(16), .WIN_CYCLES(WIN), .AVG_LOG2(AVG), .SETTLE_CYCLES(SET)
  ) dut (
    .clk(clk), .reset(reset), .ro_in(ro_in), .ro_en(ro_en), .start(start),
    .ch_mask(ch_mask), .busy(busy), .res_data(res_data), .res_ch(res_ch),
    .res_valid(res_valid), .res_ready(res_ready), .res_ovf(res_ovf)
  );

  // Narrow-counter instance for the saturation / wrap behaviour.
  ro_tempsens_scan #(
    .N_CH(N_CH), .CNT_W(4), .WIN_CYCLES(WIN), .AVG_LOG2(AVG), .SETTLE_CYCLES(SET)
  ) dut4 (
    .clk(clk), .reset(reset), .ro_in(ro_in), .ro_en(ro_en2), .start(start),
    .ch_mask(ch_mask), .busy(busy2), .res_data(res_data2), .res_ch(res_ch2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_ovf(res_ovf2)
  );

  always #5 clk = ~clk;

  // clk-aligned square waves: ch0/ch1 period 4, ch2 period 6, ch3 period 10.
  int unsigned cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (quiet) begin
      ro_in = '0;
    end else begin
      ro_in[0] = (cyc % 4) < 2;
      ro_in[1] = (cyc % 4) < 2;
      ro_in[2] = (cyc % 6) < 3;
      ro_in[3] = (cyc % 10) < 5;
    end
  end

  typedef struct {int ch; int data; int ovf;} exp_t;
  exp_t q1[$];
  exp_t q2[$];

  int  checks = 0;
  int  errors = 0;
  time t0 = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic push(input int ch, input int d1, input int d2, input int ovf2);
    exp_t e;
    e = '{ch, d1, 0};
    q1.push_back(e);
    e = '{ch, d2, ovf2};
    q2.push_back(e);
  endtask

  task automatic do_start(input logic [3:0] m);
    @(posedge clk);
    #1;
    start   = 1'b1;
    ch_mask = m;
    @(posedge clk);
    t0 = $time;
    #1;
    start   = 1'b0;
    ch_mask = 4'b1111;  // later mask changes must not matter
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!res_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid_seen"}, res_valid, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_busy_drop"}, busy, 0);
  endtask

  // Scoreboard monitors: compare the queue head on every valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (reset && res_valid) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_result got ch %0d data %0d required no result", res_ch, res_data);
      end else begin
        chk("res_ch", res_ch, q1[0].ch);
        chk("res_data", res_data, q1[0].data);
        chk("res_ovf", res_ovf, q1[0].ovf);
        if (res_ready) void'(q1.pop_front());
      end
      chk("ro_en_in_out", ro_en, 0);
    end
  end

  always @(negedge clk) begin
    if (reset && res_valid2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_result4 got ch %0d data %0d required no result", res_ch2, res_data2);
      end else begin
        chk("res_ch4", res_ch2, q2[0].ch);
        chk("res_data4", res_data2, q2[0].data);
        chk("res_ovf4", res_ovf2, q2[0].ovf);
        if (res_ready) void'(q2.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Reset state.
    #12;
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ch", res_ch, 0);
    chk("rst_res_ovf", res_ovf, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);

    // Single channel, period 4.
    push(0, 25, P4_D2, P4_O2);
    do_start(4'b0001);
    chk("single_busy_after_start", busy, 1);
    chk("single_ro_en_after_start", ro_en, 4'b0001);
    repeat (200) @(negedge clk);
    chk("single_ro_en_mid", ro_en, 4'b0001);
    wait_valid(600, "single");
    lat = int'(($time - t0 - 5) / 10);
    chk("single_latency", lat, SET + (1 << AVG) * (WIN + 1));
    wait_idle(50, "single");

    // Two channels with backpressure on the first result.
    res_ready = 1'b0;
    push(1, 25, P4_D2, P4_O2);
    push(3, 10, 10, 0);
    do_start(4'b1010);
    wait_valid(600, "multi_first");
    repeat (50) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("multi_busy_between", busy, 1);
    wait_idle(700, "multi");
    chk("multi_busy4", busy2, 0);

    // Start with empty mask is ignored.
    @(posedge clk);
    #1;
    start   = 1'b1;
    ch_mask = 4'b0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("zero_mask_busy", busy, 0);
    chk("zero_mask_ro_en", ro_en, 0);

    // A second start mid-scan adds no results.
    push(0, 25, P4_D2, P4_O2);
    do_start(4'b0001);
    repeat (20) @(posedge clk);
    #1;
    start   = 1'b1;
    ch_mask = 4'b1111;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(600, "restart");
    repeat (5) @(posedge clk);
    chk("restart_pending", q1.size(), 0);

    // Reset in the middle of a gate window.
    do_start(4'b0001);
    repeat (50) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_ro_en", ro_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_res_ch", res_ch, 0);
    chk("mid_rst_res_ovf", res_ovf, 0);
    chk("mid_rst_res_data4", res_data2, 0);
    q1.delete();
    q2.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    push(0, 25, P4_D2, P4_O2);
    do_start(4'b0001);
    wait_idle(600, "after_rst");

    // No oscillator activity on any channel.
    quiet = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 4; i++) push(i, 0, 0, 0);
    do_start(4'b1111);
    wait_idle(4 * 430, "quiet");
    quiet = 1'b0;

    repeat (3) @(posedge clk);
    chk("final_pending", q1.size(), 0);
    chk("final_pending4", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
